// File: rtl/nios_processor_band_in_if.sv
// rtl/nios_processor_band_in_if.sv - Avalon-MM slave bus bundle for the band-level sample input block
//
// Signals:
//   address    [1:0]  register select (word address)
//   chipselect        slave select
//   read_n            active-low read strobe
//   write_n           active-low write strobe
//   writedata  [31:0] CPU write data
//   readdata   [31:0] CPU read data, combinational (read latency 0)
//
// Modports:
//   master  driven by the CPU side (or a testbench)
//   slave   used by nios_processor_band_in
interface nios_processor_band_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output read_n,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read_n,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_processor_band_in.sv
// rtl/nios_processor_band_in.sv - Avalon-MM slave FIFO returning frequency-separator samples to the Nios II CPU
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   avs       Avalon-MM slave bus (nios_processor_band_in_if.slave)
//   in_data   sample from the frequency separator (DATA_WIDTH bits)
//   in_valid  one-cycle push strobe
//   irq       level interrupt: not-empty and/or overflow, each maskable
//
// Register map (word addresses):
//   0 DATA     read pops the head sample (0 when empty, no pop)
//   1 STATUS   [4:0] count, [8] empty, [9] full, [16] overflow (W1C on bit 16)
//   2 IRQMASK  [0] not-empty enable, [1] overflow enable
//   3 CONTROL  write bit 0 = 1 flushes the FIFO; reads 0
module nios_processor_band_in #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios_processor_band_in_if.slave avs,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  irq
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_CONTROL = 2'd3;

    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

    // Storage and state
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic [1:0]            irq_mask;

    // Derived status
    logic empty;
    logic full;

    // Access qualification
    logic bus_read;
    logic bus_write;
    logic pop;
    logic push;
    logic flush;
    logic overflow_set;
    logic overflow_clr;

    assign empty = (count == '0);
    assign full  = (count == COUNT_FULL);

    assign bus_read  = avs.chipselect & ~avs.read_n;
    assign bus_write = avs.chipselect & ~avs.write_n;

    assign pop   = bus_read & (avs.address == ADDR_DATA) & ~empty;
    assign flush = bus_write & (avs.address == ADDR_CONTROL) & avs.writedata[0];

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign push = in_valid & (~full | pop);

    // A sample arriving during a flush is discarded by the flush, not lost to
    // a full FIFO, so it must not count as an overflow.
    assign overflow_set = in_valid & full & ~pop & ~flush;
    assign overflow_clr = bus_write & (avs.address == ADDR_STATUS) & avs.writedata[16];

    // Sample storage: no reset needed, contents are only observed through
    // the count/pointers which are reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; flush overrides any simultaneous push or pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky overflow; a new loss in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= 2'b00;
        end else if (bus_write && (avs.address == ADDR_IRQMASK)) begin
            irq_mask <= avs.writedata[1:0];
        end
    end

    // Read mux: purely from address and registered state (latency 0).
    logic [31:0] head_word;
    logic [31:0] status_word;

    assign head_word = empty ? 32'h0 : 32'(mem[rd_ptr]);

    always_comb begin
        status_word        = 32'h0;
        status_word[4:0]   = 5'(count);
        status_word[8]     = empty;
        status_word[9]     = full;
        status_word[16]    = overflow;
    end

    always_comb begin
        avs.readdata = 32'h0;
        case (avs.address)
            ADDR_DATA:    avs.readdata = head_word;
            ADDR_STATUS:  avs.readdata = status_word;
            ADDR_IRQMASK: avs.readdata = {30'h0, irq_mask};
            ADDR_CONTROL: avs.readdata = 32'h0;
            default:      avs.readdata = 32'h0;
        endcase
    end

    // Only registered terms, so no glitches from bus inputs.
    assign irq = (irq_mask[0] & ~empty) | (irq_mask[1] & overflow);
endmodule

// File: tb/tb_nios_processor_band_in.sv
// tb/tb_nios_processor_band_in.sv - self-checking bench for nios_processor_band_in
module tb_nios_processor_band_in;
    logic        clk;
    logic        reset_n;
    logic [23:0] in_data;
    logic        in_valid;
    logic        irq;

    int checks;
    int failures;

    nios_processor_band_in_if bus ();

    nios_processor_band_in #(
        .DATA_WIDTH (24),
        .DEPTH      (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (bus.slave),
        .in_data  (in_data),
        .in_valid (in_valid),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        bit [1:0]    addr;
        bit [31:0]   wdata;
        bit          iv;
        bit [23:0]   idata;
        bit          chk_rd;
        bit [31:0]   exp_rd;
        bit          exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input bit rd, input bit wr, input bit [1:0] a,
                       input bit [31:0] wd, input bit iv, input bit [23:0] id,
                       input bit chk, input bit [31:0] exp, input bit eirq);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
        v.iv = iv; v.idata = id; v.chk_rd = chk; v.exp_rd = exp; v.exp_irq = eirq;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    // Drive one bus cycle's inputs at the falling edge, then let them settle.
    task automatic cyc(input bit rd, input bit wr, input bit [1:0] a, input bit [31:0] wd,
                       input bit iv, input bit [23:0] id);
        @(negedge clk);
        bus.chipselect = rd | wr;
        bus.read_n     = ~rd;
        bus.write_n    = ~wr;
        bus.address    = a;
        bus.writedata  = wd;
        in_valid       = iv;
        in_data        = id;
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 24'h0);
    endtask

    localparam bit R = 1'b1;
    localparam bit W = 1'b1;

    initial begin
        vec_t v;
        int q[$];
        int exp_v;

        checks   = 0;
        failures = 0;

        // Reset state and basic push/pop
        add("rst_data",    R, 0, 0, 0, 0, 0, 1, 32'h0, 0);
        add("rst_status",  R, 0, 1, 0, 0, 0, 1, 32'h100, 0);
        add("rst_mask",    R, 0, 2, 0, 0, 0, 1, 32'h0, 0);
        add("rst_ctrl",    R, 0, 3, 0, 0, 0, 1, 32'h0, 0);
        add("push1_st",    R, 0, 1, 0, 1, 24'h123456, 1, 32'h100, 0);
        add("push2_st",    R, 0, 1, 0, 1, 24'hABCDEF, 1, 32'h001, 0);
        add("st_two",      R, 0, 1, 0, 0, 0, 1, 32'h002, 0);
        add("pop_first",   R, 0, 0, 0, 0, 0, 1, 32'h00123456, 0);
        add("st_one",      R, 0, 1, 0, 0, 0, 1, 32'h001, 0);
        add("pop_second",  R, 0, 0, 0, 0, 0, 1, 32'h00ABCDEF, 0);
        add("st_empty",    R, 0, 1, 0, 0, 0, 1, 32'h100, 0);
        add("pop_empty",   R, 0, 0, 0, 0, 0, 1, 32'h0, 0);
        add("st_empty2",   R, 0, 1, 0, 0, 0, 1, 32'h100, 0);
        // Overflow: five pushes into DEPTH=4
        for (int i = 1; i <= 5; i++)
            add("ovf_push", 0, 0, 0, 0, 1, 24'(i), 0, 0, 0);
        add("ovf_status",  R, 0, 1, 0, 0, 0, 1, 32'h10204, 0);
        for (int i = 1; i <= 4; i++)
            add("ovf_pop", R, 0, 0, 0, 0, 0, 1, 32'(i), 0);
        add("ovf_drained", R, 0, 1, 0, 0, 0, 1, 32'h10100, 0);
        add("ovf_clear",   0, W, 1, 32'h10000, 0, 0, 0, 0, 0);
        add("ovf_cleared", R, 0, 1, 0, 0, 0, 1, 32'h100, 0);
        // Not-empty interrupt
        add("mask1_wr",    0, W, 2, 32'h1, 0, 0, 0, 0, 0);
        add("mask1_rd",    R, 0, 2, 0, 0, 0, 1, 32'h1, 0);
        add("irq_push",    R, 0, 1, 0, 1, 24'h0000AA, 1, 32'h100, 0);
        add("irq_high",    R, 0, 1, 0, 0, 0, 1, 32'h001, 1);
        add("irq_pop",     R, 0, 0, 0, 0, 0, 1, 32'h000000AA, 1);
        add("irq_low",     R, 0, 1, 0, 0, 0, 1, 32'h100, 0);
        // Overflow-only interrupt
        add("mask2_wr",    0, W, 2, 32'h2, 0, 0, 0, 0, 0);
        add("m2_push1",    R, 0, 1, 0, 1, 24'hB00001, 1, 32'h100, 0);
        add("m2_push2",    R, 0, 1, 0, 1, 24'hB00002, 1, 32'h001, 0);
        add("m2_push3",    R, 0, 1, 0, 1, 24'hB00003, 1, 32'h002, 0);
        add("m2_push4",    R, 0, 1, 0, 1, 24'hB00004, 1, 32'h003, 0);
        add("m2_push5",    R, 0, 1, 0, 1, 24'hB00005, 1, 32'h204, 0);
        add("m2_ovf_irq",  R, 0, 1, 0, 0, 0, 1, 32'h10204, 1);
        add("set_wins",    0, W, 1, 32'h10000, 1, 24'hB00006, 0, 0, 1);
        add("set_wins_st", R, 0, 1, 0, 0, 0, 1, 32'h10204, 1);
        add("m2_clear",    0, W, 1, 32'h10000, 0, 0, 0, 0, 1);
        add("m2_cleared",  R, 0, 1, 0, 0, 0, 1, 32'h204, 0);
        add("data_wr_ign", 0, W, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        add("data_wr_st",  R, 0, 1, 0, 0, 0, 1, 32'h204, 0);

        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'h0;
        in_valid       = 1'b0;
        in_data        = 24'h0;
        reset_n        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_irq", {31'h0, irq}, 32'h0);

        foreach (vecs[i]) begin
            v = vecs[i];
            cyc(v.rd, v.wr, v.addr, v.wdata, v.iv, v.idata);
            if (v.chk_rd) check(v.name, bus.readdata, v.exp_rd);
            check({v.name, "_irq"}, {31'h0, irq}, {31'h0, v.exp_irq});
        end

        // Full FIFO, continuous push+pop across 3*DEPTH cycles: wrap-around
        q = '{32'hB00001, 32'hB00002, 32'hB00003, 32'hB00004};
        for (int i = 0; i < 12; i++) begin
            exp_v = q.pop_front();
            q.push_back(32'hC00000 + i);
            cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 24'hC00000 + 24'(i));
            check("wrap_pop", bus.readdata, 32'(exp_v));
        end
        cyc(1'b1, 1'b0, 2'd1, 32'h0, 1'b0, 24'h0);
        check("wrap_status", bus.readdata, 32'h204);
        for (int i = 0; i < 4; i++) begin
            exp_v = q.pop_front();
            cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 24'h0);
            check("wrap_drain", bus.readdata, 32'(exp_v));
        end
        cyc(1'b1, 1'b0, 2'd1, 32'h0, 1'b0, 24'h0);
        check("wrap_empty", bus.readdata, 32'h100);

        // Flush with 3 entries and a simultaneous push
        for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 24'hD00000 + 24'(i));
        cyc(1'b0, 1'b1, 2'd3, 32'h1, 1'b1, 24'hD00004);
        cyc(1'b1, 1'b0, 2'd1, 32'h0, 1'b0, 24'h0);
        check("flush_status", bus.readdata, 32'h100);
        cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 24'h0);
        check("flush_data", bus.readdata, 32'h0);

        // Flush while full with overflow set: overflow kept, push not an overflow
        for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 24'hE00000 + 24'(i));
        cyc(1'b0, 1'b1, 2'd3, 32'h1, 1'b1, 24'hE00006);
        cyc(1'b1, 1'b0, 2'd1, 32'h0, 1'b0, 24'h0);
        check("flush_ovf_kept", bus.readdata, 32'h10100);
        cyc(1'b0, 1'b1, 2'd1, 32'h10000, 1'b0, 24'h0);
        cyc(1'b1, 1'b0, 2'd1, 32'h0, 1'b0, 24'h0);
        check("flush_ovf_clr", bus.readdata, 32'h100);

        // Asynchronous reset mid-stream
        cyc(1'b0, 1'b1, 2'd2, 32'h3, 1'b1, 24'hF00001);
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 24'hF00002);
        cyc(1'b1, 1'b0, 2'd1, 32'h0, 1'b0, 24'h0);
        check("pre_rst_status", bus.readdata, 32'h002);
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("arst_status", bus.readdata, 32'h100);
        check("arst_irq", {31'h0, irq}, 32'h0);
        bus.address = 2'd2;
        #1;
        check("arst_mask", bus.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 24'h0);
        check("post_rst_data", bus.readdata, 32'h0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
